ahb_input_stage_s0: RTL and testbench
=====================================

// Module: ahb_input_stage_s0
// PURPOSE
//  Slave-port input stage of the bus matrix, directly upstream of the S0 decoder stage.
//  Captures each master address phase in a holding register.
//  When the target output stage is not granting (active_dec low), it stalls the master
//  and replays the held transfer once the grant arrives.
//  Masks the decoder data-phase response while a held transfer is pending.
// PARAMETERS
//  ADDR_W   32   address width; decoder consumes addr_dec[31:10]
// PORTS
//  HCLK          in   1       AHB system clock
//  HRESETn       in   1       async active-low reset
//  HSELS         in   1       slave-port select from master
//  HADDRS        in   ADDR_W  master address
//  HTRANSS       in   2       master transfer type
//  HWRITES       in   1       master write
//  HSIZES        in   3       master size
//  HBURSTS       in   3       master burst
//  HPROTS        in   4       master protection
//  HMASTLOCKS    in   1       master lock
//  HREADYS       in   1       master-side HREADY (transfer done)
//  active_dec    in   1       decoder's active indication for the addressed port
//  readyout_dec  in   1       decoder-selected HREADYOUT
//  resp_dec      in   2       decoder-selected HRESP
//  sel_dec       out  1       select to decoder
//  addr_dec      out  ADDR_W  address to decoder/output stages
//  trans_dec     out  2       transfer type to decoder
//  write_dec     out  1       write to output stages
//  size_dec      out  3       size to output stages
//  burst_dec     out  3       burst to output stages
//  prot_dec      out  4       protection to output stages
//  mastlock_dec  out  1       lock to output stages
//  ready_dec     out  1       HREADY to decoder/output stages
//  HREADYOUTS    out  1       HREADYOUT back to master
//  HRESPS        out  2       HRESP back to master
// BEHAVIOUR
//  - new_tran = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ only; IDLE/BUSY never held).
//  - Holding regs (addr, trans, write, size, burst, prot, mastlock):
//    - load on every HREADYS=1 cycle with HSELS=1 and pend=0
//    - hold while pend=1
//  - pend flag:
//    - set on new_tran & ~active_dec
//    - cleared on pend & active_dec (held transfer accepted)
//    - new_tran cannot coincide with pend=1, because HREADYS=0 while pending
//  - pend=0: all *_dec outputs equal live master inputs (zero latency); sel_dec=HSELS.
//  - pend=1: outputs come from the holding regs; sel_dec=1.
//    - trans_dec: held SEQ is replayed as NONSEQ (10); NONSEQ unchanged.
//    - burst_dec: INCR4/8/16 and WRAP4/8/16 are replayed as INCR (001);
//      SINGLE/INCR unchanged.
//  - ready_dec = HREADYS | pend, so the decoder registers its data port on the replay cycle.
//  - HREADYOUTS = pend ? 0 : readyout_dec
//  - HRESPS     = pend ? 2'b00 (OKAY) : resp_dec
//  - Latency:
//    - granted transfer: 0 extra cycles
//    - ungranted transfer: master stalled for one cycle per cycle active_dec stays low,
//      plus the replay cycle
//  - Reset (async, any time incl. mid-pend):
//    - pend=0; holding regs=0 (trans=IDLE)
//    - outputs follow live inputs immediately, giving HREADYOUTS=readyout_dec and HRESPS=resp_dec
// STRUCTURE
//  - Shared package: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HRESP_OKAY.
//  - Single flat module: one register block plus output muxes; no sub-module.
// TESTING
//  1. Granted: HSELS=1, HTRANSS=NONSEQ, HADDRS=0x2000_0010, active_dec=1
//     -> addr_dec=0x2000_0010 same cycle; pend stays 0; HREADYOUTS=readyout_dec.
//  2. Stall: NONSEQ to 0x4000_0000 with active_dec=0 for 3 cycles
//     -> pend=1; HREADYOUTS=0 and HRESPS=OKAY for 3 cycles.
//     On the 4th cycle active_dec=1 -> addr_dec=0x4000_0000, ready_dec=1; pend clears next edge.
//  3. Burst break: SEQ beat of INCR4 at 0x0000_0008 held
//     -> replayed with trans_dec=NONSEQ, burst_dec=INCR, addr_dec=0x0000_0008.
//  4. IDLE/BUSY with active_dec=0 -> pend stays 0; trans_dec passes live value.
//  5. Reset asserted while pend=1 -> pend=0 asynchronously;
//     after release the next NONSEQ passes straight through.
//  6. HSELS=0 -> sel_dec=0; HREADYOUTS/HRESPS mirror readyout_dec/resp_dec.

Source files
------------

// File: rtl/ahb_input_stage_s0_pkg.sv
// Shared AHB encodings for the bus-matrix input stage.
package ahb_input_stage_s0_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  // A replayed beat starts a fresh transfer, so SEQ becomes NONSEQ.
  function automatic logic [1:0] replay_trans(input logic [1:0] t);
    if (t == HTRANS_SEQ) return HTRANS_NONSEQ;
    return t;
  endfunction

  // Fixed-length bursts are broken by the replay; continue as undefined-length INCR.
  function automatic logic [2:0] replay_burst(input logic [2:0] b);
    if (b == HBURST_SINGLE || b == HBURST_INCR) return b;
    return HBURST_INCR;
  endfunction

endpackage

// File: rtl/ahb_input_stage_s0.sv
// Slave-port input stage: holds an ungranted address phase, stalls the master,
// and replays the held transfer to the decoder once the output stage grants.
module ahb_input_stage_s0
  import ahb_input_stage_s0_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec,
  output logic              sel_dec,
  output logic [ADDR_W-1:0] addr_dec,
  output logic [1:0]        trans_dec,
  output logic              write_dec,
  output logic [2:0]        size_dec,
  output logic [2:0]        burst_dec,
  output logic [3:0]        prot_dec,
  output logic              mastlock_dec,
  output logic              ready_dec,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS
);

  logic              pend;
  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_trans;
  logic              hold_write;
  logic [2:0]        hold_size;
  logic [2:0]        hold_burst;
  logic [3:0]        hold_prot;
  logic              hold_mastlock;

  logic new_tran;
  logic load;

  // IDLE/BUSY never need a grant, so only NONSEQ/SEQ can raise pend.
  assign new_tran = HSELS & HTRANSS[1] & HREADYS;
  assign load     = HSELS & HREADYS & ~pend;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend          <= 1'b0;
      hold_addr     <= '0;
      hold_trans    <= HTRANS_IDLE;
      hold_write    <= 1'b0;
      hold_size     <= '0;
      hold_burst    <= HBURST_SINGLE;
      hold_prot     <= '0;
      hold_mastlock <= 1'b0;
    end else begin
      if (load) begin
        hold_addr     <= HADDRS;
        hold_trans    <= HTRANSS;
        hold_write    <= HWRITES;
        hold_size     <= HSIZES;
        hold_burst    <= HBURSTS;
        hold_prot     <= HPROTS;
        hold_mastlock <= HMASTLOCKS;
      end
      if (pend && active_dec) begin
        pend <= 1'b0;
      end else if (new_tran && !active_dec) begin
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_dec      = HSELS;
    addr_dec     = HADDRS;
    trans_dec    = HTRANSS;
    write_dec    = HWRITES;
    size_dec     = HSIZES;
    burst_dec    = HBURSTS;
    prot_dec     = HPROTS;
    mastlock_dec = HMASTLOCKS;
    HREADYOUTS   = readyout_dec;
    HRESPS       = resp_dec;
    if (pend) begin
      sel_dec      = 1'b1;
      addr_dec     = hold_addr;
      trans_dec    = replay_trans(hold_trans);
      write_dec    = hold_write;
      size_dec     = hold_size;
      burst_dec    = replay_burst(hold_burst);
      prot_dec     = hold_prot;
      mastlock_dec = hold_mastlock;
      HREADYOUTS   = 1'b0;
      HRESPS       = HRESP_OKAY;
    end
  end

  // Forcing ready high on the replay lets the decoder register its data-phase port.
  assign ready_dec = HREADYS | pend;

endmodule

// File: tb/tb_ahb_input_stage_s0.sv
// Directed bench for ahb_input_stage_s0 with an expected-output scoreboard.
module tb_ahb_input_stage_s0;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        sel_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic        write_dec;
  logic [2:0]  size_dec;
  logic [2:0]  burst_dec;
  logic [3:0]  prot_dec;
  logic        mastlock_dec;
  logic        ready_dec;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, WRAP8 = 3'b100;

  typedef struct {
    string       tag;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic        ready;
    logic        hreadyout;
    logic [1:0]  hresp;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  ahb_input_stage_s0 #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .sel_dec(sel_dec), .addr_dec(addr_dec), .trans_dec(trans_dec),
    .write_dec(write_dec), .size_dec(size_dec), .burst_dec(burst_dec),
    .prot_dec(prot_dec), .mastlock_dec(mastlock_dec), .ready_dec(ready_dec),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic cmp(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
    end
  endtask

  task automatic set_m(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size, input logic [2:0] burst,
                       input logic [3:0] prot, input logic lock, input logic rdy);
    HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = wr; HSIZES = size;
    HBURSTS = burst; HPROTS = prot; HMASTLOCKS = lock; HREADYS = rdy;
  endtask

  task automatic set_d(input logic act, input logic rdyout, input logic [1:0] resp);
    active_dec = act; readyout_dec = rdyout; resp_dec = resp;
  endtask

  // No transfer pending: outputs mirror the live inputs.
  task automatic push_pass(input string tag);
    exp_t e;
    e.tag = tag; e.sel = HSELS; e.addr = HADDRS; e.trans = HTRANSS; e.write = HWRITES;
    e.size = HSIZES; e.burst = HBURSTS; e.prot = HPROTS; e.lock = HMASTLOCKS;
    e.ready = HREADYS; e.hreadyout = readyout_dec; e.hresp = resp_dec;
    sb.push_back(e);
  endtask

  // Transfer pending: held values (already converted) drive the decoder, master stalled.
  task automatic push_held(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                           input logic wr, input logic [2:0] size, input logic [2:0] burst,
                           input logic [3:0] prot, input logic lock);
    exp_t e;
    e.tag = tag; e.sel = 1'b1; e.addr = addr; e.trans = trans; e.write = wr;
    e.size = size; e.burst = burst; e.prot = prot; e.lock = lock;
    e.ready = 1'b1; e.hreadyout = 1'b0; e.hresp = 2'b00;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(e.tag, "sel_dec", 32'(sel_dec), 32'(e.sel));
      cmp(e.tag, "addr_dec", addr_dec, e.addr);
      cmp(e.tag, "trans_dec", 32'(trans_dec), 32'(e.trans));
      cmp(e.tag, "write_dec", 32'(write_dec), 32'(e.write));
      cmp(e.tag, "size_dec", 32'(size_dec), 32'(e.size));
      cmp(e.tag, "burst_dec", 32'(burst_dec), 32'(e.burst));
      cmp(e.tag, "prot_dec", 32'(prot_dec), 32'(e.prot));
      cmp(e.tag, "mastlock_dec", 32'(mastlock_dec), 32'(e.lock));
      cmp(e.tag, "ready_dec", 32'(ready_dec), 32'(e.ready));
      cmp(e.tag, "HREADYOUTS", 32'(HREADYOUTS), 32'(e.hreadyout));
      cmp(e.tag, "HRESPS", 32'(HRESPS), 32'(e.hresp));
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
    check_sb();
  endtask

  initial begin
    // Reset state: outputs follow live inputs even during reset.
    HRESETn = 1'b0;
    set_m(1'b1, 32'h1234_5678, SEQ, 1'b1, 3'd2, INCR4, 4'hA, 1'b1, 1'b0);
    set_d(1'b0, 1'b1, 2'b01);
    push_pass("reset");
    #2 check_sb();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // 1. Granted transfer passes straight through.
    next_cycle();
    set_m(1'b1, 32'h2000_0010, NSQ, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    set_d(1'b1, 1'b1, 2'b00);
    push_pass("t1_addr"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h2000_0014, IDLE, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    set_d(1'b1, 1'b0, 2'b00);
    push_pass("t1_data"); at_neg();

    // 2. Ungranted NONSEQ: three stall cycles then replay.
    next_cycle();
    set_m(1'b1, 32'h4000_0000, NSQ, 1'b1, 3'd1, SINGLE, 4'h5, 1'b1, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t2_addr"); at_neg();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_m(1'b0, 32'hDEAD_BEE0, IDLE, 1'b0, 3'd0, INCR, 4'h0, 1'b0, 1'b0);
      set_d(1'b0, 1'b1, 2'b01);
      push_held("t2_stall", 32'h4000_0000, NSQ, 1'b1, 3'd1, SINGLE, 4'h5, 1'b1); at_neg();
    end
    next_cycle();
    set_d(1'b1, 1'b1, 2'b01);
    push_held("t2_replay", 32'h4000_0000, NSQ, 1'b1, 3'd1, SINGLE, 4'h5, 1'b1); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0000, IDLE, 1'b0, 3'd0, SINGLE, 4'h0, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t2_after"); at_neg();

    // 3. SEQ beat of INCR4 held: replayed as NONSEQ/INCR.
    next_cycle();
    set_m(1'b1, 32'h0000_0000, NSQ, 1'b0, 3'd2, INCR4, 4'h1, 1'b0, 1'b1);
    set_d(1'b1, 1'b1, 2'b00);
    push_pass("t3_b0"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0004, SEQ, 1'b0, 3'd2, INCR4, 4'h1, 1'b0, 1'b1);
    push_pass("t3_b1"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0008, SEQ, 1'b0, 3'd2, INCR4, 4'h1, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t3_b2"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0008, SEQ, 1'b0, 3'd2, INCR4, 4'h1, 1'b0, 1'b0);
    set_d(1'b1, 1'b1, 2'b00);
    push_held("t3_replay", 32'h0000_0008, NSQ, 1'b0, 3'd2, INCR, 4'h1, 1'b0); at_neg();

    // WRAP8 NONSEQ held: burst becomes INCR, trans stays NONSEQ.
    next_cycle();
    set_m(1'b1, 32'h0000_0100, NSQ, 1'b1, 3'd2, WRAP8, 4'h2, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t3w_addr"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0100, NSQ, 1'b1, 3'd2, WRAP8, 4'h2, 1'b0, 1'b0);
    set_d(1'b1, 1'b1, 2'b00);
    push_held("t3w_replay", 32'h0000_0100, NSQ, 1'b1, 3'd2, INCR, 4'h2, 1'b0); at_neg();

    // 4. IDLE/BUSY with no grant never raise pend.
    next_cycle();
    set_m(1'b1, 32'h0000_0200, IDLE, 1'b0, 3'd0, SINGLE, 4'h0, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t4_idle"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0204, BUSY, 1'b0, 3'd0, INCR, 4'h0, 1'b0, 1'b1);
    push_pass("t4_busy"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h0000_0208, IDLE, 1'b0, 3'd0, SINGLE, 4'h0, 1'b0, 1'b1);
    push_pass("t4_after"); at_neg();

    // 5. Reset while pending; next NONSEQ passes through.
    next_cycle();
    set_m(1'b1, 32'hC000_0000, NSQ, 1'b1, 3'd2, INCR, 4'h7, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t5_addr"); at_neg();
    next_cycle();
    set_m(1'b0, 32'hC000_0004, SEQ, 1'b0, 3'd1, SINGLE, 4'h0, 1'b0, 1'b0);
    push_held("t5_held", 32'hC000_0000, NSQ, 1'b1, 3'd2, INCR, 4'h7, 1'b0); at_neg();
    #1 HRESETn = 1'b0;
    push_pass("t5_in_reset");
    #1 check_sb();
    #1 HRESETn = 1'b1;
    next_cycle();
    set_m(1'b1, 32'h1000_0000, NSQ, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    set_d(1'b1, 1'b1, 2'b00);
    push_pass("t5_post"); at_neg();
    next_cycle();
    set_m(1'b1, 32'h1000_0004, IDLE, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    push_pass("t5_post_data"); at_neg();

    // 6. Not selected: no pend, responses mirror the decoder.
    next_cycle();
    set_m(1'b0, 32'h5000_0000, NSQ, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    set_d(1'b0, 1'b0, 2'b01);
    push_pass("t6_unsel"); at_neg();
    next_cycle();
    set_m(1'b0, 32'h5000_0004, IDLE, 1'b0, 3'd2, SINGLE, 4'h3, 1'b0, 1'b1);
    set_d(1'b0, 1'b1, 2'b00);
    push_pass("t6_after"); at_neg();

    cmp("end", "sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
